gcd_engine: RTL and testbench

Parametrised GCD engine, successor to the fixed 16-bit serial-load GCD datapath/controller pair. It accepts both operands in parallel on a valid/ready handshake and iterates one step per clock. The result is returned on a second valid/ready handshake together with a step count. It sits between an operand producer and a result consumer, and either side may stall.

---
 rtl/gcd_engine_if.sv | 34 +++
 rtl/gcd_engine.sv | 193 +++++++++++++++++++
 tb/tb_gcd_engine.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_engine_if.sv
// gcd_engine_if
// Bundles the operand handshake and the result handshake of gcd_engine.
//   in_valid / in_ready  : operand handshake, a_in/b_in qualified by in_valid
//   a_in, b_in           : unsigned operands, WIDTH bits
//   out_valid / out_ready: result handshake, gcd_out/iter_cnt qualified by out_valid
//   gcd_out              : unsigned result, WIDTH bits
//   iter_cnt             : saturating reduction-step count, CNT_W bits
//   busy                 : engine is iterating
// The engine connects to the slave modport. The producer/consumer side connects
// to the master modport.
interface gcd_engine_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] gcd_out;
  logic [CNT_W-1:0] iter_cnt;
  logic             busy;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, gcd_out, iter_cnt, busy
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, gcd_out, iter_cnt, busy
  );
endinterface

// File: rtl/gcd_engine.sv
// gcd_engine
// Iterative GCD engine. It accepts both operands on a valid/ready handshake and
// performs one reduction step per clock. It returns the result and the step
// count on a second valid/ready handshake. Only one job is in flight at a time.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, highest priority
//   bus  : gcd_engine_if slave modport (operand/result handshakes, busy)
// Parameters:
//   WIDTH : operand/result width (>= 2)
//   CNT_W : step counter width (>= 1)
// Build option:
//   GCD_STEIN_EN : when defined, RUN uses the binary (Stein) reduction step.
//                  When undefined, RUN uses the plain subtractive step and no
//                  shift hardware is built.
module gcd_engine #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  gcd_engine_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_gcd;
  logic [CNT_W-1:0] r_cnt;

  logic             w_term;
  logic             w_cntSat;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] w_aStep;
  logic [WIDTH-1:0] w_bStep;
  logic             w_inReady;
  logic             w_outValid;
  logic             w_busy;

`ifdef GCD_STEIN_EN
  // Common factors of two removed by the Stein step. At most WIDTH-1 of them
  // can be stripped from nonzero operands, so $clog2(WIDTH) bits are enough.
  localparam int KW = $clog2(WIDTH);
  logic [KW-1:0]    r_k;
  logic             w_kInc;
`endif

  // Termination test and result selection. When one operand is zero the other
  // is the answer, and two zeros give zero naturally.
  assign w_term   = (r_a == r_b) || (r_a == '0) || (r_b == '0);
  assign w_base   = (r_a == '0) ? r_b : r_a;
  assign w_cntSat = (r_cnt == {CNT_W{1'b1}});

`ifdef GCD_STEIN_EN
  // Reapply the factors of two that both operands shared.
  assign w_result = w_base << r_k;
`else
  assign w_result = w_base;
`endif

  // One reduction step. The larger operand is always the minuend, so the
  // subtraction never wraps.
  always_comb begin
    w_aStep = r_a;
    w_bStep = r_b;
`ifdef GCD_STEIN_EN
    w_kInc  = 1'b0;
    if (!r_a[0] && !r_b[0]) begin
      w_aStep = r_a >> 1;
      w_bStep = r_b >> 1;
      w_kInc  = 1'b1;
    end else if (!r_a[0]) begin
      w_aStep = r_a >> 1;
    end else if (!r_b[0]) begin
      w_bStep = r_b >> 1;
    end else if (r_a > r_b) begin
      w_aStep = r_a - r_b;
    end else begin
      w_bStep = r_b - r_a;
    end
`else
    if (r_a > r_b) begin
      w_aStep = r_a - r_b;
    end else begin
      w_bStep = r_b - r_a;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake decode. in_ready, busy and out_valid come
  // straight from the state, so operands can never be taken while a job is
  // in flight or its result is still waiting.
  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    w_outValid  = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        w_inReady = 1'b1;
        if (bus.in_valid) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        w_busy = 1'b1;
        if (w_term) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_outValid = 1'b1;
        if (bus.out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath registers. The result and the count are written only on the
  // terminate edge, and the count is cleared only when a job is accepted. Both
  // therefore stay visible after the result handshake completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_gcd <= '0;
      r_cnt <= '0;
`ifdef GCD_STEIN_EN
      r_k   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a   <= bus.a_in;
            r_b   <= bus.b_in;
            r_cnt <= '0;
`ifdef GCD_STEIN_EN
            r_k   <= '0;
`endif
          end
        end
        RUN: begin
          if (w_term) begin
            r_gcd <= w_result;
          end else begin
            r_a <= w_aStep;
            r_b <= w_bStep;
            if (!w_cntSat) begin
              r_cnt <= r_cnt + 1'b1;
            end
`ifdef GCD_STEIN_EN
            if (w_kInc) begin
              r_k <= r_k + 1'b1;
            end
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = w_outValid;
  assign bus.busy      = w_busy;
  assign bus.gcd_out   = r_gcd;
  assign bus.iter_cnt  = r_cnt;

endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine
// Self-checking bench for gcd_engine. A reference function supplies the GCD by
// Euclid's modulo method and the expected step count. Expectations are queued
// when operands are driven and popped when a result appears. A second
// instance with a 4-bit counter exercises counter saturation.
module tb_gcd_engine;

  localparam int W      = 16;
  localparam int CW     = 16;
  localparam int SCW    = 4;
  localparam int BUDGET = 5000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cycle = 0;

  always #5 clk = ~clk;

  // Free-running edge counter used to measure acceptance spacing.
  always @(posedge clk) cycle <= cycle + 1;

  gcd_engine_if #(.WIDTH(W), .CNT_W(CW))  bus ();
  gcd_engine_if #(.WIDTH(W), .CNT_W(SCW)) sbus ();

  gcd_engine #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  gcd_engine #(.WIDTH(W), .CNT_W(SCW)) dutSat (
    .clk (clk),
    .rst (rst),
    .bus (sbus.slave)
  );

  typedef struct {
    logic [W-1:0] gcd;
    int           steps;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  // Reference: GCD by repeated modulo, step count by replaying the step rule.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] g, output int steps);
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    g = x;
    x = a;
    y = b;
    steps = 0;
    while (!((x == y) || (x == 0) || (y == 0))) begin
`ifdef GCD_STEIN_EN
      if (!x[0] && !y[0]) begin
        x = x >> 1;
        y = y >> 1;
      end else if (!x[0]) begin
        x = x >> 1;
      end else if (!y[0]) begin
        y = y >> 1;
      end else if (x > y) begin
        x = x - y;
      end else begin
        y = y - x;
      end
`else
      if (x > y) x = x - y;
      else       y = y - x;
`endif
      steps++;
    end
  endfunction

  function automatic int satCnt(input int s, input int cw);
    int mx;
    mx = (1 << cw) - 1;
    return (s > mx) ? mx : s;
  endfunction

  function automatic exp_t makeExp(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    model(a, b, e.gcd, e.steps);
    return e;
  endfunction

  // Drives one job on the main instance with out_ready held high, queues its
  // expectation, and returns what the DUT showed while out_valid was high.
  // Called and returns at a falling edge, with the engine back in IDLE.
  task automatic runJob(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] g, output int c, output int lat,
                        output bit tmo);
    int w;
    tmo = 1'b0;
    bus.out_ready = 1'b1;
    w = 0;
    while (!bus.in_ready && w < BUDGET) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) tmo = 1'b1;
    bus.a_in     = a;
    bus.b_in     = b;
    bus.in_valid = 1'b1;
    sbq.push_back(makeExp(a, b));
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < BUDGET) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!bus.out_valid) tmo = 1'b1;
    g = bus.gcd_out;
    c = int'(bus.iter_cnt);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.in_valid   = 1'b0;
    bus.a_in       = '0;
    bus.b_in       = '0;
    bus.out_ready  = 1'b0;
    sbus.in_valid  = 1'b0;
    sbus.a_in      = '0;
    sbus.b_in      = '0;
    sbus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b, expected 1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_out_valid: got %b, expected 0", bus.out_valid);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_busy: got %b, expected 0", bus.busy);
    end
    checks++;
    if (bus.gcd_out !== '0) begin
      errors++;
      $display("[TB] FAIL reset_gcd_out: got %0d, expected 0", bus.gcd_out);
    end
    checks++;
    if (bus.iter_cnt !== '0) begin
      errors++;
      $display("[TB] FAIL reset_iter_cnt: got %0d, expected 0", bus.iter_cnt);
    end
    checks++;
    if ((sbus.in_ready !== 1'b1) || (sbus.out_valid !== 1'b0) || (sbus.iter_cnt !== '0)) begin
      errors++;
      $display("[TB] FAIL reset_sat_instance: got ready=%b valid=%b cnt=%0d, expected 1 0 0",
               sbus.in_ready, sbus.out_valid, sbus.iter_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [W-1:0] ta[10];
    logic [W-1:0] tb[10];
    logic [W-1:0] tg[10];
    logic [W-1:0] g;
    int           c;
    int           lat;
    bit           tmo;
    exp_t         e;
    ta = '{16'd143, 16'd0, 16'd0, 16'd48, 16'd12, 16'd21, 16'd48, 16'd0, 16'd0, 16'd0};
    tb = '{16'd78,  16'd0, 16'd12, 16'd48, 16'd0, 16'd14, 16'd18, 16'd0, 16'd0, 16'd0};
    tg = '{16'd13,  16'd0, 16'd12, 16'd48, 16'd12, 16'd7, 16'd6,  16'd0, 16'd0, 16'd0};
    // The last three slots carry random operand pairs with no fixed answer.
    for (int i = 7; i < 10; i++) begin
      ta[i] = W'($urandom_range(1, 255));
      tb[i] = W'($urandom_range(1, 255));
    end
    for (int i = 0; i < 10; i++) begin
      runJob(ta[i], tb[i], g, c, lat, tmo);
      e = sbq.pop_front();
      checks++;
      if (tmo) begin
        errors++;
        $display("[TB] FAIL basic_timeout[%0d]: got no handshake, expected completion", i);
      end
      if (i < 7) begin
        checks++;
        if (g !== tg[i]) begin
          errors++;
          $display("[TB] FAIL basic_gcd_const[%0d]: got %0d, expected %0d", i, g, tg[i]);
        end
      end
      checks++;
      if (g !== e.gcd) begin
        errors++;
        $display("[TB] FAIL basic_gcd[%0d] %0d,%0d: got %0d, expected %0d", i, ta[i], tb[i], g, e.gcd);
      end
      checks++;
      if (c != satCnt(e.steps, CW)) begin
        errors++;
        $display("[TB] FAIL basic_iter_cnt[%0d]: got %0d, expected %0d", i, c, satCnt(e.steps, CW));
      end
      checks++;
      if (lat != e.steps + 1) begin
        errors++;
        $display("[TB] FAIL basic_latency[%0d]: got %0d, expected %0d", i, lat, e.steps + 1);
      end
      checks++;
      if ((bus.gcd_out !== e.gcd) || (int'(bus.iter_cnt) != satCnt(e.steps, CW)) || (bus.in_ready !== 1'b1)) begin
        errors++;
        $display("[TB] FAIL basic_persist[%0d]: got gcd=%0d cnt=%0d ready=%b, expected %0d %0d 1",
                 i, bus.gcd_out, bus.iter_cnt, bus.in_ready, e.gcd, satCnt(e.steps, CW));
      end
      if (i == 0) begin
        checks++;
`ifdef GCD_STEIN_EN
        if ((c != 7) || (lat != 8)) begin
          errors++;
          $display("[TB] FAIL basic_143_78_steps: got cnt=%0d lat=%0d, expected 7 8", c, lat);
        end
`else
        if ((c != 6) || (lat != 7)) begin
          errors++;
          $display("[TB] FAIL basic_143_78_steps: got cnt=%0d lat=%0d, expected 6 7", c, lat);
        end
`endif
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e1;
    exp_t e2;
    int   w;
    bus.out_ready = 1'b0;
    bus.a_in      = 16'd143;
    bus.b_in      = 16'd78;
    bus.in_valid  = 1'b1;
    sbq.push_back(makeExp(16'd143, 16'd78));
    @(posedge clk);
    @(negedge clk);
    bus.a_in = 16'd35;
    bus.b_in = 16'd21;
    sbq.push_back(makeExp(16'd35, 16'd21));
    w = 0;
    while (!bus.out_valid && w < BUDGET) begin
      @(negedge clk);
      w++;
    end
    e1 = sbq.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_first_valid: got %b, expected 1", bus.out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ((bus.out_valid !== 1'b1) || (bus.gcd_out !== 16'd13) ||
          (int'(bus.iter_cnt) != satCnt(e1.steps, CW)) || (bus.in_ready !== 1'b0)) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d]: got valid=%b gcd=%0d cnt=%0d ready=%b, expected 1 13 %0d 0",
                 i, bus.out_valid, bus.gcd_out, bus.iter_cnt, bus.in_ready, satCnt(e1.steps, CW));
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ((bus.out_valid !== 1'b0) || (bus.in_ready !== 1'b1)) begin
      errors++;
      $display("[TB] FAIL bp_release: got valid=%b ready=%b, expected 0 1", bus.out_valid, bus.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_second_accept: got busy=%b, expected 1", bus.busy);
    end
    w = 0;
    while (!bus.out_valid && w < BUDGET) begin
      @(negedge clk);
      w++;
    end
    e2 = sbq.pop_front();
    checks++;
    if ((bus.out_valid !== 1'b1) || (bus.gcd_out !== e2.gcd) || (int'(bus.iter_cnt) != satCnt(e2.steps, CW))) begin
      errors++;
      $display("[TB] FAIL bp_second_result: got valid=%b gcd=%0d cnt=%0d, expected 1 %0d %0d",
               bus.out_valid, bus.gcd_out, bus.iter_cnt, e2.gcd, satCnt(e2.steps, CW));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] pa[3];
    logic [W-1:0] pb[3];
    int           acc[3];
    exp_t         e;
    int           w;
    pa = '{16'd143, 16'd35, 16'd0};
    pb = '{16'd78,  16'd21, 16'd9};
    bus.out_ready = 1'b1;
    bus.a_in      = pa[0];
    bus.b_in      = pb[0];
    bus.in_valid  = 1'b1;
    sbq.push_back(makeExp(pa[0], pb[0]));
    @(posedge clk);
    @(negedge clk);
    acc[0] = cycle;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin
        bus.a_in = pa[i+1];
        bus.b_in = pb[i+1];
        sbq.push_back(makeExp(pa[i+1], pb[i+1]));
      end else begin
        bus.in_valid = 1'b0;
      end
      w = 0;
      while (!bus.out_valid && w < BUDGET) begin
        @(negedge clk);
        w++;
      end
      e = sbq.pop_front();
      checks++;
      if ((bus.out_valid !== 1'b1) || (bus.gcd_out !== e.gcd)) begin
        errors++;
        $display("[TB] FAIL b2b_result[%0d]: got valid=%b gcd=%0d, expected 1 %0d",
                 i, bus.out_valid, bus.gcd_out, e.gcd);
      end
      if (i < 2) begin
        w = 0;
        while (!bus.in_ready && w < BUDGET) begin
          @(negedge clk);
          w++;
        end
        @(posedge clk);
        @(negedge clk);
        acc[i+1] = cycle;
        checks++;
        if (acc[i+1] - acc[i] != e.steps + 3) begin
          errors++;
          $display("[TB] FAIL b2b_spacing[%0d]: got %0d, expected %0d", i, acc[i+1] - acc[i], e.steps + 3);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] g;
    int           c;
    int           lat;
    bit           tmo;
    bit           sawValid;
    exp_t         e;
    bus.out_ready = 1'b1;
    bus.a_in      = 16'd143;
    bus.b_in      = 16'd78;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ((bus.in_ready !== 1'b1) || (bus.busy !== 1'b0) || (bus.out_valid !== 1'b0) ||
        (bus.gcd_out !== '0) || (bus.iter_cnt !== '0)) begin
      errors++;
      $display("[TB] FAIL midrun_reset_state: got ready=%b busy=%b valid=%b gcd=%0d cnt=%0d, expected 1 0 0 0 0",
               bus.in_ready, bus.busy, bus.out_valid, bus.gcd_out, bus.iter_cnt);
    end
    sawValid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid === 1'b1) sawValid = 1'b1;
    end
    checks++;
    if (sawValid) begin
      errors++;
      $display("[TB] FAIL midrun_no_result: got out_valid=1, expected 0");
    end
    runJob(16'd21, 16'd14, g, c, lat, tmo);
    e = sbq.pop_front();
    checks++;
    if (tmo || (g !== 16'd7) || (g !== e.gcd)) begin
      errors++;
      $display("[TB] FAIL midrun_next_job: got gcd=%0d timeout=%0d, expected 7", g, tmo);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    int   lat;
    sbus.out_ready = 1'b1;
    sbus.a_in      = 16'd1000;
    sbus.b_in      = 16'd1;
    sbus.in_valid  = 1'b1;
    sbq.push_back(makeExp(16'd1000, 16'd1));
    @(posedge clk);
    @(negedge clk);
    sbus.in_valid = 1'b0;
    lat = 0;
    while (!sbus.out_valid && lat < BUDGET) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    e = sbq.pop_front();
    checks++;
    if ((sbus.out_valid !== 1'b1) || (sbus.gcd_out !== 16'd1)) begin
      errors++;
      $display("[TB] FAIL sat_gcd: got valid=%b gcd=%0d, expected 1 1", sbus.out_valid, sbus.gcd_out);
    end
    checks++;
    if (int'(sbus.iter_cnt) != satCnt(e.steps, SCW)) begin
      errors++;
      $display("[TB] FAIL sat_iter_cnt: got %0d, expected %0d", sbus.iter_cnt, satCnt(e.steps, SCW));
    end
    checks++;
    if (lat != e.steps + 1) begin
      errors++;
      $display("[TB] FAIL sat_latency: got %0d, expected %0d", lat, e.steps + 1);
    end
`ifndef GCD_STEIN_EN
    checks++;
    if ((sbus.iter_cnt !== 4'd15) || (lat != 1000)) begin
      errors++;
      $display("[TB] FAIL sat_const: got cnt=%0d lat=%0d, expected 15 1000", sbus.iter_cnt, lat);
    end
`endif
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Overall time limit so a stuck handshake can never hang the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
